// File: rtl/uxn_pkg.sv
// Shared definitions for the uxn execute unit: opcode encoding, FSM states
// and bit positions inside the {E,C,Z} flag vector.
package uxn_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'h01,
        OP_SUB = 8'h02,
        OP_MUL = 8'h03,
        OP_DIV = 8'h04,
        OP_MOD = 8'h05,
        OP_AND = 8'h10,
        OP_OR  = 8'h11,
        OP_XOR = 8'h12,
        OP_NOT = 8'h13,
        OP_CMP = 8'h42
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } exec_state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_E = 2;

endpackage

// File: rtl/uxn_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first iteration is performed on the start edge itself, so a division
// takes DATA_W edges (counter 0..DATA_W-1); done pulses for one cycle after
// the last iteration, with quotient/remainder final and held until the next
// start.
module uxn_divider #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] step_dvs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              neg;

    // One restoring step; on start it works from the fresh operands.
    always_comb begin
        step_rem = start ? '0 : rem_q;
        step_quo = start ? dividend : quo_q;
        step_dvs = start ? divisor : dvs_q;
        shifted  = {step_rem, step_quo[DATA_W-1]};
        diff     = shifted - {1'b0, step_dvs};
        neg      = diff[DATA_W];
    end

    // Iteration registers and the start/busy/done sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem_q <= neg ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                quo_q <= {step_quo[DATA_W-2:0], !neg};
                dvs_q <= step_dvs;
                if (start) begin
                    busy  <= 1'b1;
                    count <= CNT_W'(1);
                end else if (count == CNT_W'(DATA_W - 1)) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/uxn_exec_unit.sv
// Multi-cycle execute unit for the uxn core.
// Build option: define UXN_EXEC_DIV_EN to include the iterative divider;
// without it DIV/MOD are treated as unknown opcodes.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and its payload steady until that edge;
// ready may change freely. Input side: in_valid/in_ready; output side:
// out_valid/out_ready, with out_data/out_flags held while out_valid is high.
module uxn_exec_unit
    import uxn_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOGIC_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_flags
);

    exec_state_t         state;
    exec_state_t         state_next;
    logic                accept;
    logic                div_path;
    logic [DATA_W-1:0]   res_data;
    logic [2:0]          res_flags;
    logic [DATA_W:0]     add_full;
    logic [2*DATA_W-1:0] mul_full;
    logic                a_nz;
    logic                b_nz;
    logic [DATA_W-1:0]   out_data_q;
    logic [2:0]          out_flags_q;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign a_nz     = (in_a != '0);
    assign b_nz     = (in_b != '0);

`ifdef UXN_EXEC_DIV_EN
    logic              op_is_mod;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_result;

    // Only a non-zero divisor needs the iterative path.
    assign div_path   = ((in_op == OP_DIV) || (in_op == OP_MOD)) && b_nz;
    assign div_result = op_is_mod ? div_rem : div_quo;

    uxn_divider #(
        .DATA_W(DATA_W)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && div_path),
        .dividend (in_a),
        .divisor  (in_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );
`else
    assign div_path = 1'b0;
`endif

    // Single-cycle result and flags, computed from the offered operands.
    always_comb begin
        res_data  = '0;
        res_flags = '0;
        add_full  = {1'b0, in_a} + {1'b0, in_b};
        mul_full  = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
        case (in_op)
            OP_ADD: begin
                res_data          = add_full[DATA_W-1:0];
                res_flags[FLAG_C] = add_full[DATA_W];
            end
            OP_SUB: begin
                res_data          = in_a - in_b;
                res_flags[FLAG_C] = (in_a < in_b);
            end
            OP_MUL: begin
                res_data          = mul_full[DATA_W-1:0];
                res_flags[FLAG_C] = |mul_full[2*DATA_W-1:DATA_W];
            end
`ifdef UXN_EXEC_DIV_EN
            // Reached as a final result only for a zero divisor.
            OP_DIV: begin
                res_data          = '1;
                res_flags[FLAG_E] = 1'b1;
            end
            OP_MOD: begin
                res_data          = in_a;
                res_flags[FLAG_E] = 1'b1;
            end
`endif
            OP_AND: res_data = (LOGIC_MODE != 0) ? DATA_W'(a_nz && b_nz) : (in_a & in_b);
            OP_OR:  res_data = (LOGIC_MODE != 0) ? DATA_W'(a_nz || b_nz) : (in_a | in_b);
            OP_XOR: res_data = (LOGIC_MODE != 0) ? DATA_W'(a_nz != b_nz) : (in_a ^ in_b);
            OP_NOT: res_data = (LOGIC_MODE != 0) ? DATA_W'(!a_nz) : ~in_a;
            OP_CMP: begin
                if (in_a == in_b) begin
                    res_data = '0;
                end else if (in_a > in_b) begin
                    res_data = DATA_W'(1);
                end else begin
                    res_data = DATA_W'(2);
                end
            end
            default: res_flags[FLAG_E] = 1'b1;
        endcase
        res_flags[FLAG_Z] = (res_data == '0);
    end

    // Next-state logic; out_valid is simply "sitting in DONE".
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_path ? DIVIDE : DONE;
                end
            end
            DIVIDE: begin
`ifdef UXN_EXEC_DIV_EN
                if (div_done && !div_busy) begin
                    state_next = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and result capture; results are frozen while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_data_q  <= '0;
            out_flags_q <= '0;
`ifdef UXN_EXEC_DIV_EN
            op_is_mod   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept && !div_path) begin
                out_data_q  <= res_data;
                out_flags_q <= res_flags;
            end
`ifdef UXN_EXEC_DIV_EN
            if (accept) begin
                op_is_mod <= (in_op == OP_MOD);
            end
            if ((state == DIVIDE) && div_done && !div_busy) begin
                out_data_q          <= div_result;
                out_flags_q         <= '0;
                out_flags_q[FLAG_Z] <= (div_result == '0);
            end
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule
